uart_rx_8n1: RTL and testbench

//  UART receiver for 8N1 serial frames, paired with the transmitter on the same link.

---
 rtl/uart_rx_8n1_pkg.sv | 33 +++
 rtl/uart_rx_8n1_sync.sv | 38 +++
 rtl/uart_rx_8n1.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_8n1_pkg.sv
// uart_rx_8n1_pkg: shared UART definitions for the 8N1 receive path.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   - line-state encodings, common with the transmitter on the same link
//   - default board clock and line rate
//   - helpers that derive clocks-per-bit and half-bit counts from them
package uart_rx_8n1_pkg;

  // Board defaults: 50 MHz system clock, 115200 baud.
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115_200;

  // Line states. These encodings are shared with the transmitter, so keep
  // them stable even if a state becomes unused on one side.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Whole-bit period in system clocks (integer division, as on the board).
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Half-bit period: distance from the start edge to the start-bit centre.
  function automatic int half_bit(input int clk_freq, input int baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_8n1_sync.sv
// uart_rx_8n1_sync: brings the asynchronous rx pin into the clk domain.
// Latency: 2 clocks pin-to-rx_s; fall is asserted in the first cycle rx_s is low.
// Backpressure: none; free-running.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-low
//   rx     in  raw serial pin, idle high
//   rx_s   out synchronised line level
//   fall   out high for one clock when rx_s has just gone 1 -> 0
module uart_rx_8n1_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // All three flops reset to the idle-line level so that leaving reset
  // never manufactures a false falling edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with a one-deep holding register.
// Latency: ~3 + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks, pin falling edge to rx_valid.
// Backpressure: none on the line; an unread byte blocks delivery and the new byte is dropped with overrun set.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low
//   rx_enable  in   permits new frames to start (looked at only while idle)
//   rx         in   asynchronous serial input, idle high
//   rx_ack     in   consumer pulse: clears rx_valid and overrun
//   rx_data    out  last accepted byte, stable while rx_valid is high
//   rx_valid   out  unread byte present in rx_data
//   busy       out  receiver is not idle
//   frame_err  out  one-clock pulse: stop bit sampled low
//   overrun    out  sticky: a good byte arrived while rx_valid was high
module uart_rx_8n1
  import uart_rx_8n1_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD     = DEF_BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int          CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int          HALF      = half_bit(CLK_FREQ, BAUD);
  localparam logic [15:0] BIT_LAST  = 16'(CPB - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  logic        rx_s;
  logic        fall;
  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        deliver;   // one-cycle strobe: shift holds a good byte

  uart_rx_8n1_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign busy = (state != ST_IDLE);

  // Line FSM. Timing is anchored on the synchronised falling edge: the
  // start bit is re-checked at its centre, after which every later sample
  // lands one full bit period further on, i.e. near each bit's centre.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'd0;
      deliver   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      deliver   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_enable && fall) begin
            state    <= ST_START;
            baud_cnt <= 16'd0;
          end
        end

        ST_START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            // A line already back high at mid-start was a glitch: drop it
            // silently rather than framing garbage.
            state    <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        ST_DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= 16'd0;
            shift    <= {rx_s, shift[7:1]};   // LSB arrives first
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        ST_STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= 16'd0;
            if (rx_s) begin
              // Returning to idle at mid-stop leaves half a bit of margin
              // for the next start edge on back-to-back traffic.
              deliver <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        ST_BREAK: begin
          // Wait for the line to recover so a held-low line (break) does
          // not immediately look like a new start bit.
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Holding register. An ack arriving in the same cycle as a delivery
  // frees the slot, so the new byte is accepted rather than dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (deliver) begin
      if (!rx_valid || rx_ack) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
        if (rx_ack) begin
          overrun <= 1'b0;
        end
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: randomized and directed scoreboard bench for uart_rx_8n1.
// Latency: n/a.
// Backpressure: the bench consumer acks automatically or holds bytes unread, per phase.
module tb_uart_rx_8n1;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int CPB      = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_enable = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_8n1 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_enable (rx_enable),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int checks = 0;
  int fails  = 0;

  // Scoreboard state and consumer model.
  logic [7:0] exp_q[$];
  int         err_exp = 0;
  bit         auto_ack = 1'b1;
  bit         ack_req = 1'b0;
  bit         manual_ack = 1'b0;
  bit         mon_en = 1'b0;
  bit         seen = 1'b0;
  bit         model_valid = 1'b0;
  bit         model_overrun = 1'b0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] pop_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of what one frame should produce, from the protocol
  // rules: disabled frames vanish, bad stop -> one error pulse, good stop ->
  // a byte for the consumer, unless the consumer still holds one unread.
  task automatic expect_frame(input logic [7:0] b, input bit ok);
    if (!rx_enable) return;
    if (!ok) begin
      err_exp++;
    end else if (auto_ack) begin
      exp_q.push_back(b);
    end else if (!model_valid) begin
      exp_q.push_back(b);
      model_valid = 1'b1;
      model_data  = b;
    end else begin
      model_overrun = 1'b1;
    end
  endtask

  // Monitor: a new presentation is a rising rx_valid.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (rx_valid && !seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(rx_data), 32'h100);
        end else begin
          pop_byte = exp_q.pop_front();
          check("byte", 32'(rx_data), 32'(pop_byte));
          if (auto_ack) begin
            check("overrun_low", 32'(overrun), 32'd0);
            ack_req = 1'b1;
          end
        end
      end
      if (!rx_valid) seen = 1'b0;
      if (frame_err) begin
        check("frame_err_expected", 32'(err_exp > 0), 32'd1);
        if (err_exp > 0) err_exp--;
      end
    end
  end

  // Consumer ack driver: one-clock pulse shortly after a request.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rx_ack     = ack_req | manual_ack;
      ack_req    = 1'b0;
      manual_ack = 1'b0;
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_ok);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || err_exp != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size() + err_exp), 32'd0);
    exp_q.delete();
    err_exp = 0;
  endtask

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    rx_enable = 1'b1;
    mon_en = 1'b1;
    idle(5);

    // Single good frame.
    expect_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1);
    idle(5);
    wait_drain("single_55");

    // Back-to-back, consumer acks each byte.
    expect_frame(8'hA3, 1'b1);
    expect_frame(8'h0F, 1'b1);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(5);
    wait_drain("b2b");
    check("b2b_overrun", 32'(overrun), 32'd0);

    // Consumer stalls: second byte must be dropped with overrun.
    auto_ack = 1'b0;
    expect_frame(8'h11, 1'b1);
    expect_frame(8'h22, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    wait_drain("stall");
    check("stall_rx_data", 32'(rx_data), 32'(model_data));
    check("stall_rx_valid", 32'(rx_valid), 32'(model_valid));
    check("stall_overrun", 32'(overrun), 32'(model_overrun));
    manual_ack = 1'b1;
    repeat (3) @(negedge clk);
    model_valid = 1'b0;
    model_overrun = 1'b0;
    check("ack_rx_valid", 32'(rx_valid), 32'(model_valid));
    check("ack_overrun", 32'(overrun), 32'(model_overrun));
    auto_ack = 1'b1;

    // Bad stop bit with the line then held low (break).
    expect_frame(8'hC4, 1'b0);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b_of(8'hC4, i));
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    check("break_rx_valid", 32'(rx_valid), 32'd0);
    repeat (10) @(negedge clk);
    idle(6);
    check("break_released_busy", 32'(busy), 32'd0);
    wait_drain("break");

    // Short glitch: rejected at the start-bit centre.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_start", 32'(busy), 32'd1);
    idle(12);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_rx_valid", 32'(rx_valid), 32'd0);
    wait_drain("glitch");

    // Enable dropped mid-frame: frame still completes.
    expect_frame(8'h96, 1'b1);
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (30) @(negedge clk);
        rx_enable = 1'b0;
      end
    join
    idle(5);
    wait_drain("en_drop");
    // Disabled: a whole frame must be ignored.
    expect_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(10);
    check("disabled_busy", 32'(busy), 32'd0);
    check("disabled_rx_valid", 32'(rx_valid), 32'd0);
    rx_enable = 1'b1;
    idle(5);

    // Randomized traffic with occasional framing errors.
    for (int n = 0; n < 12; n++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      expect_frame(b, ok);
      send_frame(b, ok);
      if (!ok) begin
        rx = 1'b0;
        repeat ($urandom_range(0, 20)) @(negedge clk);
        gap = $urandom_range(5, 15);
      end else begin
        gap = $urandom_range(0, 15);
      end
      idle(gap);
    end
    idle(5);
    wait_drain("random");

    // Reset in the middle of a frame, then a clean byte.
    b = 8'h7E;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(b[i]);
    rx = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    reset = 1'b1;
    idle(15);
    expect_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1);
    idle(5);
    wait_drain("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  function automatic logic b_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule
